// File: rtl/serial_bit_streamer_if.sv
// Word-in / bit-out bus of serial_bit_streamer: parallel load handshake plus the
// qualified serial stream that feeds a pattern detector.
interface serial_bit_streamer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             out;
  logic             out_vld;
  logic             done;

  modport master (output din, load, input  ready, out, out_vld, done);
  modport slave  (input  din, load, output ready, out, out_vld, done);
endinterface

// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial streamer: one WIDTH-bit word per frame, one bit per clock.
// Define STREAM_PARITY_EN to append an even-parity bit to every frame.
module serial_bit_streamer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                  ck,
  input logic                  r,
  serial_bit_streamer_if.slave bus
);
`ifdef STREAM_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [FRAME-1:0] sreg, sreg_n, frame_c;
  logic [CW-1:0]    cnt, cnt_n;
  logic             out_q, out_n;
  logic             out_vld_q, out_vld_n;
  logic             done_q, done_n;
  logic             ready_c, accept_c;

  // The frame register is kept with the next bit to send at the head end.
  function automatic logic head(input logic [FRAME-1:0] v);
    return MSB_FIRST ? v[FRAME-1] : v[0];
  endfunction

  function automatic logic [FRAME-1:0] advance(input logic [FRAME-1:0] v);
    return MSB_FIRST ? {v[FRAME-2:0], 1'b0} : {1'b0, v[FRAME-1:1]};
  endfunction

  // Full frame as captured at accept, parity placed after the data bits.
  always_comb begin
`ifdef STREAM_PARITY_EN
    frame_c = MSB_FIRST ? {bus.din, ^bus.din} : {^bus.din, bus.din};
`else
    frame_c = bus.din;
`endif
  end

  assign ready_c  = r & ((state == IDLE) | ((state == SHIFT) & (cnt == LAST)));
  assign accept_c = bus.load & ready_c;

  always_ff @(posedge ck) begin
    if (!r) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out_q     <= 1'b0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      out_q     <= out_n;
      out_vld_q <= out_vld_n;
      done_q    <= done_n;
    end
  end

  // Outputs default to idle (0); a frame bit is only driven while streaming.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    out_n     = 1'b0;
    out_vld_n = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_n   = SHIFT;
          out_n     = head(frame_c);
          sreg_n    = advance(frame_c);
          cnt_n     = '0;
          out_vld_n = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_n     = cnt + CW'(1);
          out_n     = head(sreg);
          sreg_n    = advance(sreg);
          out_vld_n = 1'b1;
          done_n    = (cnt_n == LAST);
        end else if (accept_c) begin
          out_n     = head(frame_c);
          sreg_n    = advance(frame_c);
          cnt_n     = '0;
          out_vld_n = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready   = ready_c;
  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed bench for serial_bit_streamer: an MSB-first and an LSB-first instance
// sharing clock and reset; frame length follows STREAM_PARITY_EN.
module tb_serial_bit_streamer;
  localparam int unsigned WIDTH = 8;
`ifdef STREAM_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic ck = 1'b0;
  logic r;
  int   checks = 0;
  int   errors = 0;

  always #5 ck = ~ck;

  serial_bit_streamer_if #(.WIDTH(WIDTH)) bus_m ();
  serial_bit_streamer_if #(.WIDTH(WIDTH)) bus_l ();

  serial_bit_streamer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (.ck(ck), .r(r), .bus(bus_m));
  serial_bit_streamer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (.ck(ck), .r(r), .bus(bus_l));

  // Expected bit k of a frame: data bits in send order, then the parity bit.
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input logic par,
                                   input int k, input bit msb);
    logic [WIDTH-1:0] t;
    if (k >= int'(WIDTH)) return par;
    t = msb ? (w << k) : (w >> k);
    return msb ? t[WIDTH-1] : t[0];
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b0;
    bus_m.load = 1'b1; bus_m.din = 8'hA5;
    bus_l.load = 1'b1; bus_l.din = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus_m.ready, bus_m.out, bus_m.out_vld, bus_m.done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold_m cyc %0d: rdy/out/vld/done=%b expected 0000", i,
                 {bus_m.ready, bus_m.out, bus_m.out_vld, bus_m.done});
      end
      checks++;
      if ({bus_l.ready, bus_l.out_vld} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold_l cyc %0d: rdy/vld=%b expected 00", i,
                 {bus_l.ready, bus_l.out_vld});
      end
    end
    r = 1'b1;
    #1;
    checks++;
    if ({bus_m.ready, bus_l.ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 11", {bus_m.ready, bus_l.ready});
    end
    bus_m.load = 1'b0;
    bus_l.load = 1'b0;
    step();
    checks++;
    if ({bus_m.out_vld, bus_l.out_vld} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_accept: out_vld=%b expected 00", {bus_m.out_vld, bus_l.out_vld});
    end
  endtask

  task automatic test_single_word();
    logic e;
    bus_m.din = 8'hA5; bus_m.load = 1'b1;
    step();
    bus_m.load = 1'b0;
    bus_m.din  = 8'h3C;
    for (int k = 0; k < int'(FRAME); k++) begin
      e = exp_bit(8'hA5, 1'b0, k, 1'b1);
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done, bus_m.ready} !==
          {e, 1'b1, k == int'(FRAME) - 1, k == int'(FRAME) - 1}) begin
        errors++;
        $display("FAIL single_bit%0d: out/vld/done/rdy=%b expected %b", k,
                 {bus_m.out, bus_m.out_vld, bus_m.done, bus_m.ready},
                 {e, 1'b1, k == int'(FRAME) - 1, k == int'(FRAME) - 1});
      end
      step();
    end
    checks++;
    if ({bus_m.out, bus_m.out_vld, bus_m.done, bus_m.ready} !== 4'b0001) begin
      errors++;
      $display("FAIL single_after: out/vld/done/rdy=%b expected 0001",
               {bus_m.out, bus_m.out_vld, bus_m.done, bus_m.ready});
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   det;  // two-1s Moore detector: 0=A, 1=B, 2=C
    det = 0;
    bus_m.din = 8'hFF; bus_m.load = 1'b1;
    step();
    bus_m.din = 8'h00;
    for (int k = 0; k < 2 * int'(FRAME); k++) begin
      if (k == int'(FRAME)) bus_m.load = 1'b0;
      e = (k < int'(FRAME)) ? exp_bit(8'hFF, 1'b0, k, 1'b1)
                            : exp_bit(8'h00, 1'b0, k - int'(FRAME), 1'b1);
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done} !==
          {e, 1'b1, (k == int'(FRAME) - 1) || (k == 2 * int'(FRAME) - 1)}) begin
        errors++;
        $display("FAIL b2b_bit%0d: out/vld/done=%b expected %b", k,
                 {bus_m.out, bus_m.out_vld, bus_m.done},
                 {e, 1'b1, (k == int'(FRAME) - 1) || (k == 2 * int'(FRAME) - 1)});
      end
      if (bus_m.out_vld === 1'b1)
        det = (bus_m.out === 1'b1) ? ((det == 0) ? 1 : 2) : 0;
      if (k == 1) begin
        checks++;
        if (det != 2) begin
          errors++;
          $display("FAIL b2b_detector_c: state %0d expected 2", det);
        end
      end
      if (k == int'(WIDTH)) begin
        checks++;
        if (det != 0) begin
          errors++;
          $display("FAIL b2b_detector_a: state %0d expected 0", det);
        end
      end
      step();
    end
    checks++;
    if ({bus_m.out, bus_m.out_vld} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after: out/vld=%b expected 00", {bus_m.out, bus_m.out_vld});
    end
  endtask

  task automatic test_ignored_load();
    logic e;
    bus_l.din = 8'h01; bus_l.load = 1'b1;
    step();
    bus_l.load = 1'b0;
    for (int k = 0; k < int'(FRAME); k++) begin
      if (k == 3) begin
        bus_l.din  = 8'hF0;
        bus_l.load = 1'b1;
        checks++;
        if (bus_l.ready !== 1'b0) begin
          errors++;
          $display("FAIL ignored_ready: got %b expected 0", bus_l.ready);
        end
      end
      if (k == 4) bus_l.load = 1'b0;
      e = exp_bit(8'h01, 1'b1, k, 1'b0);
      checks++;
      if ({bus_l.out, bus_l.out_vld, bus_l.done} !== {e, 1'b1, k == int'(FRAME) - 1}) begin
        errors++;
        $display("FAIL lsb_bit%0d: out/vld/done=%b expected %b", k,
                 {bus_l.out, bus_l.out_vld, bus_l.done}, {e, 1'b1, k == int'(FRAME) - 1});
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus_l.out, bus_l.out_vld, bus_l.ready} !== 3'b001) begin
        errors++;
        $display("FAIL ignored_not_sent cyc %0d: out/vld/rdy=%b expected 001", i,
                 {bus_l.out, bus_l.out_vld, bus_l.ready});
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic e;
    bus_m.din = 8'hFF; bus_m.load = 1'b1;
    step();
    bus_m.load = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done} !== 3'b110) begin
        errors++;
        $display("FAIL abort_pre_bit%0d: out/vld/done=%b expected 110", k,
                 {bus_m.out, bus_m.out_vld, bus_m.done});
      end
      if (k == 4) begin
        r = 1'b0;
        bus_m.load = 1'b1;
        checks++;
        if (bus_m.ready !== 1'b0) begin
          errors++;
          $display("FAIL abort_ready: got %b expected 0", bus_m.ready);
        end
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle cyc %0d: out/vld/done=%b expected 000", i,
                 {bus_m.out, bus_m.out_vld, bus_m.done});
      end
      step();
    end
    r = 1'b1;
    bus_m.load = 1'b0;
    step();
    checks++;
    if ({bus_m.out_vld, bus_m.done, bus_m.ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_released: vld/done/rdy=%b expected 001",
               {bus_m.out_vld, bus_m.done, bus_m.ready});
    end
    bus_m.din = 8'h81; bus_m.load = 1'b1;
    step();
    bus_m.load = 1'b0;
    for (int k = 0; k < int'(FRAME); k++) begin
      e = exp_bit(8'h81, 1'b0, k, 1'b1);
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done} !== {e, 1'b1, k == int'(FRAME) - 1}) begin
        errors++;
        $display("FAIL restart_bit%0d: out/vld/done=%b expected %b", k,
                 {bus_m.out, bus_m.out_vld, bus_m.done}, {e, 1'b1, k == int'(FRAME) - 1});
      end
      step();
    end
  endtask

  task automatic test_parity();
    logic e;
    bus_m.din = 8'h07; bus_m.load = 1'b1;
    step();
    bus_m.load = 1'b0;
    for (int k = 0; k < int'(FRAME); k++) begin
      e = exp_bit(8'h07, 1'b1, k, 1'b1);
      checks++;
      if ({bus_m.out, bus_m.out_vld, bus_m.done} !== {e, 1'b1, k == int'(FRAME) - 1}) begin
        errors++;
        $display("FAIL parity_bit%0d: out/vld/done=%b expected %b", k,
                 {bus_m.out, bus_m.out_vld, bus_m.done}, {e, 1'b1, k == int'(FRAME) - 1});
      end
      step();
    end
    checks++;
    if ({bus_m.out, bus_m.out_vld, bus_m.done} !== 3'b000) begin
      errors++;
      $display("FAIL parity_after: out/vld/done=%b expected 000",
               {bus_m.out, bus_m.out_vld, bus_m.done});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
